// File: rtl/sma_pulse_ctrl_if.sv
// Avalon-MM slave bus bundle for the SMA pulse controller: address, select,
// write strobe and data going in, combinational read data coming back.
interface sma_pulse_ctrl_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/sma_pulse_ctrl.sv
// Programmable pulse-train generator for the SMA output pin. Software sets
// PERIOD/HIGH/COUNT over the bus, then START runs the train from shadow copies.
module sma_pulse_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  sma_pulse_ctrl_if.slave  bus,
  output logic             out_port,
  output logic             irq
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACT   = 2'd1,
    INACT = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] period_reg, high_reg, count_reg;
  logic [CNT_W-1:0] sh_period, sh_high, sh_count;
  logic [CNT_W-1:0] phase, phase_nxt;
  logic [CNT_W-1:0] pulse_cnt, pulse_nxt;
  logic             idle_level, idle_level_nxt;
  logic             irq_en, done, err;
  logic             load_shadow, set_done, set_err;
  logic             wr, wr_ctrl, start_req, stop_req, cfg_ok, busy, out_nxt;
  logic             unused_wdata;

  assign wr        = bus.chipselect && !bus.write_n;
  assign wr_ctrl   = wr && (bus.address == 2'd0);
  assign start_req = wr_ctrl && bus.writedata[0];
  assign stop_req  = wr_ctrl && bus.writedata[1];
  assign cfg_ok    = (period_reg >= CNT_W'(2)) && (high_reg != '0) && (high_reg < period_reg);
  assign busy      = (state != IDLE);
  assign irq       = done && irq_en;
  assign unused_wdata = ^bus.writedata;

  // A level written in this cycle drives out_port at the same edge, so a
  // running train flips polarity without waiting for its next phase change.
  assign idle_level_nxt = wr_ctrl ? bus.writedata[2] : idle_level;
  assign out_nxt        = (state_nxt == ACT) ? ~idle_level_nxt : idle_level_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // phase counts cycles within the current period; STOP overrides everything.
  always_comb begin
    state_nxt   = state;
    phase_nxt   = phase;
    pulse_nxt   = pulse_cnt;
    load_shadow = 1'b0;
    set_done    = 1'b0;
    set_err     = 1'b0;
    if (stop_req) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start_req) begin
            if (cfg_ok) begin
              state_nxt   = ACT;
              phase_nxt   = '0;
              pulse_nxt   = '0;
              load_shadow = 1'b1;
            end else begin
              set_err = 1'b1;
            end
          end
        end
        ACT: begin
          phase_nxt = phase + CNT_W'(1);
          if (phase == sh_high - CNT_W'(1)) begin
            state_nxt = INACT;
          end
        end
        INACT: begin
          if (phase == sh_period - CNT_W'(1)) begin
            phase_nxt = '0;
            pulse_nxt = pulse_cnt + CNT_W'(1);
            if ((sh_count != '0) && (pulse_nxt == sh_count)) begin
              state_nxt = IDLE;
              set_done  = 1'b1;
            end else begin
              state_nxt = ACT;
            end
          end else begin
            phase_nxt = phase + CNT_W'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_reg <= '0;
      high_reg   <= '0;
      count_reg  <= '0;
      sh_period  <= '0;
      sh_high    <= '0;
      sh_count   <= '0;
      phase      <= '0;
      pulse_cnt  <= '0;
      idle_level <= 1'b0;
      irq_en     <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      out_port   <= 1'b0;
    end else begin
      phase      <= phase_nxt;
      pulse_cnt  <= pulse_nxt;
      idle_level <= idle_level_nxt;
      out_port   <= out_nxt;
      // A flag being set wins over its clear strobe in the same cycle.
      done <= set_done || (done && !(wr_ctrl && bus.writedata[4]));
      err  <= set_err  || (err  && !(wr_ctrl && bus.writedata[5]));
      if (wr_ctrl) begin
        irq_en <= bus.writedata[3];
      end
      if (wr && bus.address == 2'd1) period_reg <= bus.writedata[CNT_W-1:0];
      if (wr && bus.address == 2'd2) high_reg   <= bus.writedata[CNT_W-1:0];
      if (wr && bus.address == 2'd3) count_reg  <= bus.writedata[CNT_W-1:0];
      if (load_shadow) begin
        sh_period <= period_reg;
        sh_high   <= high_reg;
        sh_count  <= count_reg;
      end
    end
  end

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      2'd0:    bus.readdata = {26'd0, err, done, irq_en, idle_level, 1'b0, busy};
      2'd1:    bus.readdata = 32'(period_reg);
      2'd2:    bus.readdata = 32'(high_reg);
      default: bus.readdata = 32'(count_reg);
    endcase
  end

endmodule

// File: tb/tb_sma_pulse_ctrl.sv
// Scoreboard bench for sma_pulse_ctrl: directed scenarios plus random bus
// traffic, with out_port/irq/readdata predicted from an offset-in-train model.
module tb_sma_pulse_ctrl;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic out_port, irq;

  sma_pulse_ctrl_if bus_if ();

  sma_pulse_ctrl #(.CNT_W(16)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus_if),
    .out_port (out_port),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        outp;
    logic        irqv;
    logic [31:0] rd;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: programmed registers, flags, and the running train as
  // "k edges since START" against the latched period/high/count.
  logic [15:0] m_period, m_high, m_count;
  bit          m_idle, m_irqen, m_done, m_err, running;
  longint      k, rp, rh, rc;
  logic [1:0]  cur_a;
  bit          cur_wr;
  logic [31:0] cur_d;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic bit expOut();
    if (running && ((k % rp) < rh)) return ~m_idle;
    return m_idle;
  endfunction

  function automatic logic [31:0] expRead(input logic [1:0] a);
    case (a)
      2'd0:    return {26'd0, m_err, m_done, m_irqen, m_idle, 1'b0, running};
      2'd1:    return {16'd0, m_period};
      2'd2:    return {16'd0, m_high};
      default: return {16'd0, m_count};
    endcase
  endfunction

  task automatic modelReset();
    m_period = '0; m_high = '0; m_count = '0;
    m_idle = 0; m_irqen = 0; m_done = 0; m_err = 0; running = 0;
    k = 0; rp = 1; rh = 0; rc = 0;
    cur_a = 2'd0; cur_wr = 0; cur_d = '0;
  endtask

  task automatic modelEdge(input logic [1:0] a, input bit wr, input logic [31:0] d);
    bit wctrl, st, sp, finish, seterr;
    wctrl = wr && (a == 2'd0);
    st = wctrl && d[0];
    sp = wctrl && d[1];
    finish = 0;
    seterr = 0;
    if (running) begin
      k++;
      if (sp) running = 0;
      else if (rc != 0 && k == rc * rp) begin
        running = 0;
        finish = 1;
      end
    end else if (st && !sp) begin
      if (m_period >= 2 && m_high >= 1 && m_high < m_period) begin
        running = 1; k = 0;
        rp = longint'(m_period); rh = longint'(m_high); rc = longint'(m_count);
      end else begin
        seterr = 1;
      end
    end
    m_done = finish || (m_done && !(wctrl && d[4]));
    m_err  = seterr || (m_err && !(wctrl && d[5]));
    if (wctrl) begin
      m_idle  = d[2];
      m_irqen = d[3];
    end
    if (wr && a == 2'd1) m_period = d[15:0];
    if (wr && a == 2'd2) m_high   = d[15:0];
    if (wr && a == 2'd3) m_count  = d[15:0];
  endtask

  // Consume the edge that sampled the previous inputs, present new inputs,
  // and queue what the DUT must show for the rest of this cycle.
  task automatic applyStimulus(input logic [1:0] a, input bit wr, input logic [31:0] d);
    exp_t e;
    @(posedge clk);
    #1;
    modelEdge(cur_a, cur_wr, cur_d);
    cur_a = a; cur_wr = wr; cur_d = d;
    bus_if.address   = a;
    bus_if.writedata = d;
    if (wr) begin
      bus_if.chipselect = 1'b1;
      bus_if.write_n    = 1'b0;
    end else if ($urandom_range(0, 1) == 1) begin
      bus_if.chipselect = 1'b1;
      bus_if.write_n    = 1'b1;
    end else begin
      bus_if.chipselect = 1'b0;
      bus_if.write_n    = 1'($urandom_range(0, 1));
    end
    e.outp = expOut();
    e.irqv = m_done && m_irqen;
    e.rd   = expRead(a);
    exp_q.push_back(e);
  endtask

  task automatic wrReg(input logic [1:0] a, input logic [31:0] d);
    applyStimulus(a, 1'b1, d);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(2'($urandom_range(0, 3)), 1'b0, $urandom);
  endtask

  task automatic doReset();
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.writedata  = '0;
    #1;
    checkOutput("reset_out_port", {31'd0, out_port}, 32'd0);
    checkOutput("reset_irq", {31'd0, irq}, 32'd0);
    for (int a = 0; a < 4; a++) begin
      bus_if.address = 2'(a);
      #1;
      checkOutput("reset_readdata", bus_if.readdata, 32'd0);
    end
    repeat (2) @(negedge clk);
    #1;
    bus_if.address = 2'd0;
    reset_n = 1'b1;
    modelReset();
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checkOutput("out_port", {31'd0, out_port}, {31'd0, e.outp});
      checkOutput("irq", {31'd0, irq}, {31'd0, e.irqv});
      checkOutput("readdata", bus_if.readdata, e.rd);
    end
  end

  initial begin
    int guard;
    logic [31:0] d;
    bus_if.address = 2'd0;
    bus_if.chipselect = 1'b0;
    bus_if.write_n = 1'b1;
    bus_if.writedata = '0;
    modelReset();
    doReset();
    $display("[TB] reset done");

    // Basic limited train with interrupt, then DONE_CLR.
    wrReg(2'd1, 32'd5); wrReg(2'd2, 32'd2); wrReg(2'd3, 32'd3);
    wrReg(2'd0, 32'h08);
    wrReg(2'd0, 32'h09);
    for (int i = 0; i < 18; i++) applyStimulus(2'd0, 1'b0, $urandom);
    wrReg(2'd0, 32'h18);
    idleCycles(3);

    // Inverted continuous train, then STOP keeping the idle level high.
    wrReg(2'd1, 32'd4); wrReg(2'd2, 32'd1); wrReg(2'd3, 32'd0);
    wrReg(2'd0, 32'h04);
    wrReg(2'd0, 32'h05);
    idleCycles(100);
    wrReg(2'd0, 32'h06);
    idleCycles(4);

    // Invalid configurations raise ERR; ERR_CLR drops it.
    wrReg(2'd1, 32'd3); wrReg(2'd2, 32'd3);
    wrReg(2'd0, 32'h05);
    idleCycles(3);
    wrReg(2'd0, 32'h24);
    wrReg(2'd2, 32'd0);
    wrReg(2'd0, 32'h01);
    idleCycles(2);
    wrReg(2'd0, 32'h20);

    // Shadowing, START while busy, IDLE_LEVEL flip mid-train, restart.
    wrReg(2'd1, 32'd5); wrReg(2'd2, 32'd2); wrReg(2'd3, 32'd2);
    wrReg(2'd0, 32'h09);
    idleCycles(2);
    wrReg(2'd1, 32'd10);
    wrReg(2'd0, 32'h09);
    wrReg(2'd0, 32'h0d);
    wrReg(2'd0, 32'h09);
    idleCycles(8);
    wrReg(2'd0, 32'h19);
    idleCycles(24);

    // START|STOP from IDLE stays idle.
    wrReg(2'd0, 32'h03);
    idleCycles(3);

    // DONE_CLR lands on the completion edge: the set wins.
    wrReg(2'd1, 32'd3); wrReg(2'd2, 32'd1); wrReg(2'd3, 32'd2);
    wrReg(2'd0, 32'h09);
    idleCycles(5);
    wrReg(2'd0, 32'h18);
    idleCycles(3);

    // Random bus traffic.
    for (int i = 0; i < 400; i++) begin
      int op;
      op = $urandom_range(0, 9);
      d = $urandom;
      if (op < 3) begin
        d[15:0] = 16'($urandom_range(0, 7));
        wrReg(2'($urandom_range(1, 3)), d);
      end else if (op < 5) begin
        d[0] = 1'($urandom_range(0, 1));
        d[1] = ($urandom_range(0, 7) == 0);
        wrReg(2'd0, d);
      end else begin
        applyStimulus(2'($urandom_range(0, 3)), 1'b0, d);
      end
    end
    wrReg(2'd0, 32'h02);
    idleCycles(2);

    // Asynchronous reset while the pulse is high: no DONE afterwards.
    wrReg(2'd1, 32'd6); wrReg(2'd2, 32'd3); wrReg(2'd3, 32'd1);
    wrReg(2'd0, 32'h09);
    guard = 0;
    applyStimulus(2'd0, 1'b0, $urandom);
    while (!(running && expOut() == 1'b1) && guard < 20) begin
      applyStimulus(2'd0, 1'b0, $urandom);
      guard++;
    end
    if (guard >= 20) checkOutput("midpulse_wait", 32'd0, 32'd1);
    doReset();
    for (int i = 0; i < 12; i++) applyStimulus(2'd0, 1'b0, $urandom);

    @(negedge clk);
    @(negedge clk);
    #1;
    checkOutput("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
